// File: rtl/hdc_pkg.sv
// Shared types and constants for the HD language-recognition front end.
package hdc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    FLUSH,
    DRAIN,
    QUERY,
    WAIT,
    RESULT
  } state_t;

  localparam int                  LETTER_W    = 5;
  localparam logic [LETTER_W-1:0] SPACE_CODE  = 5'd26;
  localparam int                  DEF_N       = 10000;
  localparam int                  DEF_NUMLANG = 22;

endpackage

// File: rtl/ascii_letter_map.sv
// Combinational ASCII byte to letter code: a..z / A..Z -> 0..25, anything else -> space.
module ascii_letter_map
  import hdc_pkg::*;
(
  input  logic [7:0]          ascii,
  output logic [LETTER_W-1:0] code
);

  logic is_lower;
  logic is_upper;

  assign is_lower = (ascii >= 8'h61) && (ascii <= 8'h7a);
  assign is_upper = (ascii >= 8'h41) && (ascii <= 8'h5a);

  // Both letter ranges start at low bits 5'b00001, so one subtract serves both cases.
  always_comb begin
    code = SPACE_CODE;
    if (is_lower || is_upper) code = ascii[4:0] - 5'd1;
  end

endmodule

// File: rtl/text_stream_controller.sv
// Sequencer: character stream -> letter strobes -> AM search -> result handshake.
// Optional letter counter output when HDC_LETTER_COUNT_EN is defined.
//   IDLE wait for text | CLEAR clear RI | STREAM accept chars | FLUSH end of text
//   DRAIN settle RI    | QUERY start AM | WAIT wait for done  | RESULT hold result
module text_stream_controller
  import hdc_pkg::*;
#(
  parameter int N            = DEF_N,
  parameter int PRECISION    = $clog2(N),
  parameter int NUMLANG      = DEF_NUMLANG,
  parameter int LOG_NUMLANG  = $clog2(NUMLANG),
  parameter int DRAIN_CYCLES = 4,
  parameter int TIMEOUT      = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   charValid,
  input  logic [7:0]             charData,
  input  logic                   charLast,
  output logic                   charReady,
  input  logic                   argmaxMode,
  output logic                   letterReady,
  output logic [LETTER_W-1:0]    inputLetter,
  output logic                   textDone,
  output logic                   rst_RI,
  output logic                   computeAngle,
  output logic                   argmax,
  input  logic                   done,
  input  logic [LOG_NUMLANG-1:0] bestMatchID,
  input  logic [PRECISION-1:0]   distance,
  output logic                   resultValid,
  input  logic                   resultReady,
  output logic [LOG_NUMLANG-1:0] resultID,
  output logic [PRECISION-1:0]   resultDistance,
`ifdef HDC_LETTER_COUNT_EN
  output logic [15:0]            letterCount,
`endif
  output logic                   timeoutErr,
  output logic                   busy
);

  localparam int CNT_MAX = (TIMEOUT > DRAIN_CYCLES) ? TIMEOUT : DRAIN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD   = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [LETTER_W-1:0]  code;
  logic                 accept;
  logic                 cnt_zero;

  ascii_letter_map u_map (
    .ascii (charData),
    .code  (code)
  );

  assign accept   = charValid && (state_q == STREAM);
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    charReady   = 1'b0;
    rst_RI      = 1'b0;
    resultValid = 1'b0;
    busy        = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (charValid) state_d = CLEAR;
      end
      CLEAR: begin
        rst_RI  = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        charReady = 1'b1;
        if (accept && charLast) state_d = FLUSH;
      end
      FLUSH:  state_d = (DRAIN_CYCLES == 0) ? QUERY : DRAIN;
      DRAIN:  if (cnt_zero) state_d = QUERY;
      QUERY:  state_d = WAIT;
      WAIT:   if (done || cnt_zero) state_d = RESULT;
      RESULT: begin
        resultValid = 1'b1;
        if (resultReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One down-counter serves both the drain interval and the done timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        FLUSH:       cnt_q <= DRAIN_LOAD;
        QUERY:       cnt_q <= TIMEOUT_LOAD;
        DRAIN, WAIT: if (!cnt_zero) cnt_q <= cnt_q - CNT_W'(1);
        default:     cnt_q <= cnt_q;
      endcase
    end
  end

  // Strobes are registered so textDone lands one cycle after the final letterReady.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      letterReady  <= 1'b0;
      inputLetter  <= '0;
      textDone     <= 1'b0;
      computeAngle <= 1'b0;
      argmax       <= 1'b0;
    end else begin
      letterReady  <= accept;
      textDone     <= (state_q == FLUSH);
      computeAngle <= (state_q == QUERY);
      if (accept) inputLetter <= code;
      if (state_q == IDLE && charValid) argmax <= argmaxMode;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resultID       <= '0;
      resultDistance <= '0;
      timeoutErr     <= 1'b0;
    end else if (state_q == WAIT) begin
      if (done) begin
        resultID       <= bestMatchID;
        resultDistance <= distance;
      end else if (cnt_zero) begin
        resultID       <= '0;
        resultDistance <= '1;
        timeoutErr     <= 1'b1;
      end
    end
  end

`ifdef HDC_LETTER_COUNT_EN
  // Only moves in CLEAR/STREAM, so it already holds the text's count through RESULT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      letterCount <= '0;
    end else if (state_q == CLEAR) begin
      letterCount <= '0;
    end else if (accept && (letterCount != 16'hFFFF)) begin
      letterCount <= letterCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_text_stream_controller.sv
// Bench for text_stream_controller: planned-schedule reference model plus directed literal pins.
module tb_text_stream_controller;

  localparam int PREC  = 14;
  localparam int LOGN  = 5;
  localparam int DRAIN = 4;
  localparam int TMO   = 1023;
  localparam int NEVER = 32'h7fffffff;

  logic            clk = 1'b0;
  logic            rst;
  logic            charValid, charLast, charReady, argmaxMode;
  logic [7:0]      charData;
  logic            letterReady, textDone, rst_RI, computeAngle, argmax;
  logic [4:0]      inputLetter;
  logic            done, resultValid, resultReady, timeoutErr, busy;
  logic [LOGN-1:0] bestMatchID, resultID;
  logic [PREC-1:0] distance, resultDistance;
`ifdef HDC_LETTER_COUNT_EN
  logic [15:0]     letterCount;
`endif
  logic [7:0]      map_in;
  logic [4:0]      map_code;

  always #5 clk = ~clk;

  text_stream_controller #(
    .N(10000), .PRECISION(PREC), .NUMLANG(22), .LOG_NUMLANG(LOGN),
    .DRAIN_CYCLES(DRAIN), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .charValid(charValid), .charData(charData), .charLast(charLast), .charReady(charReady),
    .argmaxMode(argmaxMode), .letterReady(letterReady), .inputLetter(inputLetter),
    .textDone(textDone), .rst_RI(rst_RI), .computeAngle(computeAngle), .argmax(argmax),
    .done(done), .bestMatchID(bestMatchID), .distance(distance),
    .resultValid(resultValid), .resultReady(resultReady),
    .resultID(resultID), .resultDistance(resultDistance),
`ifdef HDC_LETTER_COUNT_EN
    .letterCount(letterCount),
`endif
    .timeoutErr(timeoutErr), .busy(busy)
  );

  ascii_letter_map u_map (.ascii(map_in), .code(map_code));

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: expected event cycles for the text currently planned.
  bit  active = 1'b0;
  bit  chk_en = 1'b0;
  int  m_s, m_al, m_tc, m_tr, m_tacc;
  bit  m_to;
  int  m_id, m_dist;
  bit  m_mode = 1'b0;
  bit  prev_mode = 1'b0;
  int  err_from = NEVER;
  int  letter_exp[int];
  logic [7:0] plan_chars[$];
  int  plan_gaps[$];
  int  got_letters[$];
  int  last_rid, last_rdist, td_cyc, ca_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int map_ch(input logic [7:0] c);
    if (c >= 8'h61 && c <= 8'h7a) return int'(c) - 97;
    if (c >= 8'h41 && c <= 8'h5a) return int'(c) - 65;
    return 26;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    int  n;
    bit  win;
    bit  exp_lr;
    n = cyc;
    if (letterReady === 1'b1) got_letters.push_back(int'(inputLetter));
    if (resultValid === 1'b1) begin
      last_rid   = int'(resultID);
      last_rdist = int'(resultDistance);
    end
    if (textDone === 1'b1) td_cyc = n;
    if (computeAngle === 1'b1) ca_cyc = n;
    if (chk_en) begin
      win    = active && n >= m_s && n <= m_tacc;
      exp_lr = letter_exp.exists(n);
      chk("busy",         busy,         int'(win && n >= m_s + 1));
      chk("rst_RI",       rst_RI,       int'(win && n == m_s + 1));
      chk("charReady",    charReady,    int'(win && n >= m_s + 2 && n <= m_al));
      chk("letterReady",  letterReady,  int'(exp_lr));
      if (exp_lr) begin
        chk("inputLetter", inputLetter, letter_exp[n]);
        letter_exp.delete(n);
      end
      chk("textDone",     textDone,     int'(win && n == m_al + 2));
      chk("computeAngle", computeAngle, int'(win && n == m_tc));
      chk("resultValid",  resultValid,  int'(win && n >= m_tr));
      if (win && n >= m_tr) begin
        chk("resultID",       resultID,       m_id);
        chk("resultDistance", resultDistance, m_dist);
      end
      chk("timeoutErr", timeoutErr, int'(n >= err_from));
      chk("argmax",     argmax,     int'((active && n >= m_s + 1) ? m_mode : prev_mode));
    end
  end

  // Plans one text from plan_chars/plan_gaps, records the expected schedule, then drives it.
  task automatic run_text(input bit mode, input int done_dly, input int hold,
                          input int rid, input int rdist);
    int s, a, nb, tdone, kk;
    int acc[$];
    nb = plan_chars.size();
    s  = cyc + 1;
    a  = s + 2;
    for (int k = 0; k < nb; k++) begin
      if (k > 0) a = a + 1;
      a = a + plan_gaps[k];
      acc.push_back(a);
      letter_exp[a + 1] = map_ch(plan_chars[k]);
    end
    prev_mode = m_mode;
    m_mode    = mode;
    m_s  = s;
    m_al = a;
    m_tc = a + 3 + DRAIN;
    if (done_dly >= 0 && done_dly < TMO) begin
      m_to = 1'b0; tdone = m_tc + done_dly; m_tr = tdone + 1;
      m_id = rid;  m_dist = rdist;
    end else begin
      m_to = 1'b1; tdone = NEVER; m_tr = m_tc + TMO;
      m_id = 0;    m_dist = (1 << PREC) - 1;
      if (err_from == NEVER) err_from = m_tr;
    end
    m_tacc = m_tr + hold;
    active = 1'b1;
    for (int n = s; n <= m_tacc; n++) begin
      @(posedge clk); #1;
      kk = -1;
      for (int k = 0; k < nb; k++) if (acc[k] == n) kk = k;
      argmaxMode = (n == s) ? mode : 1'($urandom_range(0, 1));
      if (n == s || n == s + 1) begin
        charValid = 1'b1; charData = plan_chars[0]; charLast = 1'b0;
      end else if (kk >= 0) begin
        charValid = 1'b1; charData = plan_chars[kk]; charLast = (kk == nb - 1);
      end else if (n <= m_al) begin
        charValid = 1'b0; charData = 8'($urandom); charLast = 1'($urandom_range(0, 1));
      end else begin
        charValid = 1'($urandom_range(0, 1)); charData = 8'($urandom);
        charLast  = 1'($urandom_range(0, 1));
      end
      if (n == tdone) begin
        done = 1'b1; bestMatchID = LOGN'(rid); distance = PREC'(rdist);
      end else begin
        done = (n < m_tc || n >= m_tr) ? ($urandom_range(0, 5) == 0) : 1'b0;
        bestMatchID = LOGN'($urandom_range(0, 21)); distance = PREC'($urandom);
      end
      if (n == m_tacc)  resultReady = 1'b1;
      else if (n < m_tr) resultReady = 1'($urandom_range(0, 1));
      else              resultReady = 1'b0;
    end
    @(posedge clk); #1;
    charValid = 1'b0; done = 1'b0; resultReady = 1'b0;
  endtask

  task automatic plan_random(input int nb);
    plan_chars.delete(); plan_gaps.delete();
    for (int k = 0; k < nb; k++) begin
      case ($urandom_range(0, 3))
        0:       plan_chars.push_back(8'($urandom));
        1:       plan_chars.push_back(8'(8'h41 + $urandom_range(0, 25)));
        default: plan_chars.push_back(8'(8'h61 + $urandom_range(0, 25)));
      endcase
      plan_gaps.push_back(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_charReady"},   charReady,    0);
    chk({tag, "_letterReady"}, letterReady,  0);
    chk({tag, "_inputLetter"}, inputLetter,  0);
    chk({tag, "_textDone"},    textDone,     0);
    chk({tag, "_rst_RI"},      rst_RI,       0);
    chk({tag, "_compute"},     computeAngle, 0);
    chk({tag, "_argmax"},      argmax,       0);
    chk({tag, "_resultValid"}, resultValid,  0);
    chk({tag, "_resultID"},    resultID,     0);
    chk({tag, "_resultDist"},  resultDistance, 0);
    chk({tag, "_timeoutErr"},  timeoutErr,   0);
    chk({tag, "_busy"},        busy,         0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_l[$];
    rst = 1'b0; charValid = 1'b0; charData = '0; charLast = 1'b0; argmaxMode = 1'b0;
    done = 1'b0; bestMatchID = '0; distance = '0; resultReady = 1'b0; map_in = '0;
    #2;
    chk_all_zero("reset");
    for (int b = 0; b < 256; b++) begin
      map_in = 8'(b); #1;
      chk("map", map_code, map_ch(8'(b)));
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // "Ab c", done 10 cycles after computeAngle, result held 5 cycles.
    plan_chars = '{8'h41, 8'h62, 8'h20, 8'h63}; plan_gaps = '{0, 0, 0, 0};
    got_letters.delete();
    run_text(1'b0, 10, 5, 7, 4321);
    exp_l = '{0, 1, 26, 2};
    chk("ab_c_count", got_letters.size(), 4);
    for (int i = 0; i < 4 && i < got_letters.size(); i++) chk("ab_c_letter", got_letters[i], exp_l[i]);
    chk("ab_c_drain", ca_cyc - td_cyc, 5);
    chk("ab_c_id", last_rid, 7);
    chk("ab_c_dist", last_rdist, 4321);

    // "0!Z" with gaps.
    plan_chars = '{8'h30, 8'h21, 8'h5a}; plan_gaps = '{1, 2, 0};
    got_letters.delete();
    run_text(1'b1, 3, 0, 12, 99);
    exp_l = '{26, 26, 25};
    chk("sym_count", got_letters.size(), 3);
    for (int i = 0; i < 3 && i < got_letters.size(); i++) chk("sym_letter", got_letters[i], exp_l[i]);

    // done in the very cycle the timeout would expire: done wins.
    plan_chars = '{8'h68, 8'h69}; plan_gaps = '{0, 1};
    run_text(1'b0, TMO - 1, 1, 21, 16000);
    chk("edge_no_err", timeoutErr, 0);
    chk("edge_id", last_rid, 21);

    // done never arrives.
    plan_chars = '{8'h6b}; plan_gaps = '{0};
    run_text(1'b1, -1, 2, 0, 0);
    chk("to_err", timeoutErr, 1);
    chk("to_id", last_rid, 0);
    chk("to_dist", last_rdist, 16383);

    for (int t = 0; t < 12; t++) begin
      plan_random(int'($urandom_range(1, 10)));
      run_text(1'($urandom_range(0, 1)), int'($urandom_range(1, 40)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 21)), int'($urandom_range(0, 16383)));
    end

    // Asynchronous reset in the middle of a text.
    chk_en = 1'b0;
    @(posedge clk); #1; charValid = 1'b1; charData = 8'h71; charLast = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_charReady", charReady, 1);
    @(posedge clk); #1;
    chk("pre_rst_letterReady", letterReady, 1);
    #2 rst = 1'b0;
    #1 chk_all_zero("midrst");
    charValid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    active = 1'b0; letter_exp.delete(); err_from = NEVER; prev_mode = 1'b0; m_mode = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    plan_random(5);
    run_text(1'b1, 7, 1, 3, 1234);
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
